rf_wr_arbiter: RTL

Arbiter for the single register-file write port. It shares the port between the pipeline writeback stage, which has priority and no backpressure, and a long-latency unit (multiplier/divider result return) that uses a valid/ready handshake. Long-latency results are buffered in a small FIFO and drained on idle WB cycles. A starvation counter forces a one-cycle WB stall, and a pending-address mask is exported so decode can stall on hazards.

---
 rtl/rf_wr_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: WB has priority, long-latency results are buffered in a
// small FIFO, drained on idle WB cycles, with a starvation stall and a pending-register mask.
module rf_wr_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_we,
  input  logic [4:0]  ws_waddr,
  input  logic [31:0] ws_wdata,
  output logic        ws_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask,
  output logic        err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      mem_addr [FIFO_DEPTH];
  logic [31:0]     mem_data [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [StvW-1:0] starve_q;
  logic            err_q;

  logic ws_eff, enq, deq, fifo_nempty;

  assign fifo_nempty = (count_q != '0);
  assign ws_eff      = ws_we && (ws_waddr != 5'd0);
  assign lu_ready    = (count_q < CntW'(FIFO_DEPTH));
  assign enq         = lu_valid && lu_ready && (lu_waddr != 5'd0);
  assign ws_stall    = (starve_q == StvW'(STARVE_LIMIT)) && fifo_nempty;
  assign deq         = fifo_nempty && (!ws_eff || ws_stall);
  assign err         = err_q;

  // FIFO head takes priority over WB whenever it is allowed to drain.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (resetn) begin
      if (deq) begin
        rf_we    = 1'b1;
        rf_waddr = mem_addr[rd_ptr_q];
        rf_wdata = mem_data[rd_ptr_q];
      end else if (ws_eff) begin
        rf_we    = 1'b1;
        rf_waddr = ws_waddr;
        rf_wdata = ws_wdata;
      end
    end
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PtrW-1:0] off;
    pend_mask = 32'd0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      off = PtrW'(i) - rd_ptr_q;
      if (CntW'(off) < count_q) begin
        pend_mask[mem_addr[i]] = 1'b1;
      end
    end
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_addr[wr_ptr_q] <= lu_waddr;
      mem_data[wr_ptr_q] <= lu_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(enq) - CntW'(deq);
      if (!fifo_nempty || deq) begin
        starve_q <= '0;
      end else if (ws_eff) begin
        starve_q <= starve_q + 1'b1;
      end
      if (ws_eff && !ws_stall && pend_mask[ws_waddr]) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
